// File: rtl/shift_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : shift_ex_stage
//  Description : Two-stage 16-bit shift/rotate execute stage with valid/ready
//                handshakes on both sides.
//                S1 performs the coarse shift (multiples of 4 bits), and
//                S2 performs the fine shift (0-3 bits) and holds the result.
//                Only the valid bits are reset; the datapath registers are not.
//                Optional feature: define SHIFT_ZERO_FLAG_EN to add out_zero,
//                a registered result==0 flag that is qualified by out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_ex_stage #(
    parameter logic [15:0] IDLE_DATA = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_cnt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic        out_zero
`endif
);

    // Operation encodings
    localparam logic [1:0] c_OP_ROL = 2'b00;
    localparam logic [1:0] c_OP_SLL = 2'b01;
    localparam logic [1:0] c_OP_ROR = 2'b10;
    localparam logic [1:0] c_OP_SRL = 2'b11;

    // Shift or rotate d by amt. A rotate is built by shifting a doubled copy
    // of the operand, so the bits leaving one end re-enter at the other.
    // Both stages use this, so applying a coarse step and then a fine step
    // composes to the full shift amount for every op.
    function automatic logic [15:0] f_shift(
        input logic [15:0] d,
        input logic [1:0]  op,
        input logic [3:0]  amt
    );
        logic [31:0] dbl;
        logic [15:0] res;
        dbl = {d, d};
        res = d;
        case (op)
            c_OP_ROL: begin
                dbl = dbl << amt;
                res = dbl[31:16];
            end
            c_OP_SLL: res = d << amt;
            c_OP_ROR: begin
                dbl = dbl >> amt;
                res = dbl[15:0];
            end
            c_OP_SRL: res = d >> amt;
            default:  res = d;
        endcase
        return res;
    endfunction

    // Stage 1 registers: partial result plus the controls S2 still needs
    logic        r_s1_valid;
    logic [15:0] r_s1_data;
    logic [1:0]  r_s1_op;
    logic [1:0]  r_s1_fcnt;

    // Stage 2 registers: final result
    logic        r_s2_valid;
    logic [15:0] r_s2_data;
`ifdef SHIFT_ZERO_FLAG_EN
    logic        r_s2_zero;
`endif

    // Combinational control and datapath
    logic        w_kill;
    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_in_fire;
    logic        w_out_live;
    logic [15:0] w_s1_coarse;
    logic [15:0] w_s2_fine;

    // Pipeline advance / handshake control; in_ready depends on out_ready
    // combinationally so a full pipeline can still take a beat while it drains.
    always_comb begin
        w_kill    = rst || flush;
        w_s2_adv  = !r_s2_valid || out_ready;
        w_s1_adv  = !r_s1_valid || w_s2_adv;
        in_ready  = !w_kill && w_s1_adv;
        w_in_fire = in_valid && in_ready;
    end

    // Coarse shift on the incoming operand, fine shift on the S1 partial
    always_comb begin
        w_s1_coarse = f_shift(in_data, in_op, {in_cnt[3:2], 2'b00});
        w_s2_fine   = f_shift(r_s1_data, r_s1_op, {2'b00, r_s1_fcnt});
    end

    // Valid bits: reset dominates flush, flush dominates normal advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_in_fire;
            end
        end
    end

    // Datapath registers load only on a real transfer and carry no reset
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_data <= w_s1_coarse;
            r_s1_op   <= in_op;
            r_s1_fcnt <= in_cnt[1:0];
        end
        if (w_s2_adv && r_s1_valid) begin
            r_s2_data <= w_s2_fine;
`ifdef SHIFT_ZERO_FLAG_EN
            r_s2_zero <= (w_s2_fine == 16'h0000);
`endif
        end
    end

    // Output drive: a kill cycle presents no beat so no transfer can complete
    always_comb begin
        w_out_live = r_s2_valid && !w_kill;
        out_valid  = w_out_live;
        out_data   = w_out_live ? r_s2_data : IDLE_DATA;
`ifdef SHIFT_ZERO_FLAG_EN
        out_zero   = w_out_live && r_s2_zero;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_ex_stage
//  Description : Scoreboard bench for shift_ex_stage. Expected results are
//                queued when a beat is accepted and compared when the stage
//                emits a beat. Define SHIFT_ZERO_FLAG_EN to cover out_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_ex_stage;

    localparam logic [15:0] IDLE = 16'h0000;
    localparam logic [1:0] ROL = 2'b00, SLL = 2'b01, ROR = 2'b10, SRL = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_cnt = 4'h0;
    logic [1:0]  in_op = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
`ifdef SHIFT_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_acc = 0;
    logic [15:0] sb_q[$];
    bit          p_hold = 1'b0;
    logic [15:0] p_data = 16'h0;

    shift_ex_stage #(.IDLE_DATA(IDLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_cnt   (in_cnt),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef SHIFT_ZERO_FLAG_EN
        ,
        .out_zero (out_zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: one bit per step
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] op,
                                              input logic [3:0] n);
        for (int i = 0; i < int'(n); i++) begin
            case (op)
                ROL:     d = {d[14:0], d[15]};
                SLL:     d = {d[14:0], 1'b0};
                ROR:     d = {d[0], d[15:1]};
                default: d = {1'b0, d[15:1]};
            endcase
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded)
    task automatic send(input logic [15:0] d, input logic [1:0] op, input logic [3:0] c);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_cnt   = c;
        #1;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) chk("send_timeout", k, 0);
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_shift(in_data, in_op, in_cnt));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", out_data, e);
`ifdef SHIFT_ZERO_FLAG_EN
                    chk("out_zero", out_zero, (e == 16'h0));
`endif
                end
            end
        end
        if (!out_valid) begin
            chk("idle_data", out_data, IDLE);
`ifdef SHIFT_ZERO_FLAG_EN
            chk("idle_zero", out_zero, 0);
`endif
        end
        if (p_hold && !rst && !flush) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, p_data);
        end
        p_hold = out_valid && !out_ready;
        p_data = out_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int acc0;
        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, IDLE);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // ROL 8001 by 1, two-cycle latency
        send(16'h8001, ROL, 4'd1);
        chk("lat_c1_valid", out_valid, 0);
        tick();
        chk("lat_c2_valid", out_valid, 1);
        chk("rol_8001", out_data, 16'h0003);
        tick();

        // Back-to-back beats, one result per cycle
        send(16'h00FF, SLL, 4'd4);
        send(16'h0001, ROR, 4'd1);
        chk("b2b_0", out_data, 16'h0FF0);
        send(16'h8000, SRL, 4'd15);
        chk("b2b_1", out_data, 16'h8000);
        tick();
        chk("b2b_2", out_data, 16'h0001);
        repeat (2) tick();

        // Backpressure: 3 beats offered with out_ready low
        out_ready = 1'b0;
        acc0 = n_acc;
        send(16'hF0F0, SRL, 4'd5);
        send(16'h1234, ROR, 4'd8);
        in_valid = 1'b1; in_data = 16'h0003; in_op = SLL; in_cnt = 4'd14;
        #1;
        chk("bp_in_ready", in_ready, 0);
        repeat (3) begin
            tick();
            chk("bp_held_valid", out_valid, 1);
            chk("bp_held_data", out_data, 16'h0787);
            chk("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_accepts", n_acc - acc0, 3);
        chk("bp_drained", sb_q.size(), 0);

        // Flush with two beats in flight
        out_ready = 1'b0;
        send(16'hAAAA, ROL, 4'd3);
        send(16'h5555, SRL, 4'd2);
        in_valid = 1'b1; in_data = 16'hFFFF; in_op = SLL; in_cnt = 4'd1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        tick();
        chk("flush_empty", out_valid, 0);
        send(16'h1234, ROL, 4'd4);
        tick();
        chk("post_flush_valid", out_valid, 1);
        chk("post_flush_data", out_data, 16'h2341);
        tick();

        // Reset mid-stream
        send(16'h0F0F, ROL, 4'd7);
        send(16'h4321, SLL, 4'd9);
        in_valid = 1'b1; in_data = 16'h7777; in_op = ROR; in_cnt = 4'd3;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 0);
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, IDLE);
        chk("midrst_in_ready2", in_ready, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("midrst_no_output", out_valid, 0);
        repeat (2) tick();

        // Zero-result flag cases
        send(16'h0001, SLL, 4'd0);
        send(16'h0001, SRL, 4'd1);
        chk("cnt0_pass", out_data, 16'h0001);
`ifdef SHIFT_ZERO_FLAG_EN
        chk("zero_flag_0", out_zero, 0);
`endif
        tick();
        chk("srl_to_zero", out_data, 16'h0000);
`ifdef SHIFT_ZERO_FLAG_EN
        chk("zero_flag_1", out_zero, 1);
`endif
        tick();

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 16'($urandom);
            in_op     = 2'($urandom_range(3));
            in_cnt    = 4'($urandom_range(15));
            out_ready = ($urandom_range(2) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rand_drained", sb_q.size(), 0);
        chk("rand_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
